// File: rtl/tc_bus_arbiter_if.sv
// rtl/tc_bus_arbiter_if.sv - requester and timer-bus signal bundle for tc_bus_arbiter (lock port with TC_ARB_LOCK_EN)
interface tc_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              tc_write;
    logic              tc_read;
    logic [ADDR_W-1:0] tc_addr;
    logic [DATA_W-1:0] tc_wdata;
    logic [DATA_W-1:0] tc_rdata;
    logic              tc_irq;
    logic              irq_out;
`ifdef TC_ARB_LOCK_EN
    logic [1:0]        lock;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, tc_rdata, tc_irq, lock,
        output gnt, done, err, rdata, tc_write, tc_read, tc_addr, tc_wdata, irq_out
    );
    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, tc_rdata, tc_irq, lock,
        input  gnt, done, err, rdata, tc_write, tc_read, tc_addr, tc_wdata, irq_out
    );
`else
    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, tc_rdata, tc_irq,
        output gnt, done, err, rdata, tc_write, tc_read, tc_addr, tc_wdata, irq_out
    );
    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, tc_rdata, tc_irq,
        input  gnt, done, err, rdata, tc_write, tc_read, tc_addr, tc_wdata, irq_out
    );
`endif
endinterface

// File: rtl/tc_bus_arbiter.sv
// rtl/tc_bus_arbiter.sv - two-requester round-robin arbiter and access sequencer for the timer register bus (optional TC_ARB_LOCK_EN)
module tc_bus_arbiter #(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    tc_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;

    // WAIT runs RD_LAT-1 cycles, so tc_rdata is sampled RD_LAT cycles after the strobe cycle
    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t            state_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic              err_q;
    logic              tc_write_q;
    logic              tc_read_q;
    logic              irq_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] tc_wdata_q;
    logic [ADDR_W-1:0] tc_addr_q;
    logic              win_q;
    logic              we_q;
    logic              legal_q;
    logic              prio_q;     // requester favoured on a tie
    logic [2:0]        cnt_q;

    logic              win_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_legal;

`ifdef TC_ARB_LOCK_EN
    logic              hold_q;     // previous winner asked to keep the bus
    logic              hold_id_q;
`endif

    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(8'h15)) ||
               ((a >= ADDR_W'(8'h24)) && (a <= ADDR_W'(8'h28))) ||
               ((a >= ADDR_W'(8'h44)) && (a <= ADDR_W'(8'h47))) ||
               (a == ADDR_W'(8'h6E));
    endfunction

    // Pick the requester to grant from IDLE: round-robin on a tie, lock overrides
    always_comb begin
        win_d = (bus.req == 2'b11) ? prio_q : bus.req[1];
`ifdef TC_ARB_LOCK_EN
        if (hold_q && bus.req[hold_id_q]) begin
            win_d = hold_id_q;
        end
`endif
    end

    assign sel_addr  = win_d ? bus.addr1 : bus.addr0;
    assign sel_wdata = win_d ? bus.wdata1 : bus.wdata0;
    assign sel_we    = bus.we[win_d];
    assign sel_legal = addr_legal(sel_addr);

    // Access sequencer: grant, strobe, optional read wait, one-cycle response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            tc_write_q <= 1'b0;
            tc_read_q  <= 1'b0;
            rdata_q    <= '0;
            tc_addr_q  <= '0;
            tc_wdata_q <= '0;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            legal_q    <= 1'b0;
            prio_q     <= 1'b0;
            cnt_q      <= 3'd0;
`ifdef TC_ARB_LOCK_EN
            hold_q     <= 1'b0;
            hold_id_q  <= 1'b0;
`endif
        end else begin
            tc_write_q <= 1'b0;
            tc_read_q  <= 1'b0;
            done_q     <= 2'b00;
            case (state_q)
                IDLE: begin
`ifdef TC_ARB_LOCK_EN
                    if (hold_q && !bus.req[hold_id_q]) begin
                        hold_q <= 1'b0;
                    end
`endif
                    if (|bus.req) begin
                        win_q      <= win_d;
                        gnt_q      <= win_d ? 2'b10 : 2'b01;
                        tc_addr_q  <= sel_addr;
                        tc_wdata_q <= sel_wdata;
                        we_q       <= sel_we;
                        legal_q    <= sel_legal;
                        tc_write_q <= sel_legal && sel_we;
                        tc_read_q  <= sel_legal && !sel_we;
                        state_q    <= STROBE;
                    end
                end
                STROBE: begin
                    if (!legal_q) begin
                        err_q   <= 1'b1;
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else if (we_q) begin
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else if (RD_LAT == 1) begin
                        rdata_q <= bus.tc_rdata;
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        rdata_q <= bus.tc_rdata;
                        done_q  <= gnt_q;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    prio_q  <= ~win_q;
                    gnt_q   <= 2'b00;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
`ifdef TC_ARB_LOCK_EN
                    hold_q    <= bus.lock[win_q];
                    hold_id_q <= win_q;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Interrupt pass-through, one clock of delay, unrelated to the sequencer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= bus.tc_irq;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.rdata    = rdata_q;
    assign bus.tc_write = tc_write_q;
    assign bus.tc_read  = tc_read_q;
    assign bus.tc_addr  = tc_addr_q;
    assign bus.tc_wdata = tc_wdata_q;
    assign bus.irq_out  = irq_q;
endmodule
